tpu_ctrl: RTL and testbench
===========================

TPU_CTRL -- requirements
Module: tpu_ctrl

Interface
REQ-001 Parameters SHALL be:
- BITS_AB, 8, A/B element width.
- BITS_C, 16, C element width.
- DIM, 8, array dimension.
- ADDRW, 16, host address width.
- DATAW, 64, host data width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- r_w  in  1  0 = read, 1 = write; sampled every cycle.
- addr  in  ADDRW  host byte address.
- dataIn  in  DATAW  host write data.
- dataOut  out  DATAW  registered host read data.
- a_en, a_wren  out  1  memA enable and row write.
- a_row  out  $clog2(DIM)  memA row index.
- a_din  out  DIM*BITS_AB  memA row data.
- b_en  out  1  memB shift enable.
- b_din  out  DIM*BITS_AB  memB row data.
- sa_en, sa_wren  out  1  systolic array enable and C-row write.
- sa_crow  out  $clog2(DIM)  C row index.
- sa_cin  out  DIM*BITS_C  C row write data.
- sa_cout  in  DIM*BITS_C  C row read data for sa_crow.
- busy, done  out  1  status outputs.

Function
REQ-003 Address map SHALL be:
- A: 0x100-0x13F, row = addr[5:3].
- B: 0x200-0x23F, one row per write.
- C: 0x300-0x37F, row = addr[6:4], half = addr[3] (0 = bits [63:0], 1 = bits [127:64]).
- CTRL/STATUS: 0x400.
- Any other address: write ignored, read returns 0.
REQ-004 The state machine SHALL have two states, IDLE and RUN.
REQ-005 In IDLE, a write to A SHALL assert a_en=a_wren=1 for exactly one cycle, with a_row and a_din=dataIn driven in that same cycle.
REQ-006 In IDLE, a write to B SHALL assert b_en=1 for exactly one cycle, with b_din=dataIn.
REQ-007 A C write with half=0 SHALL latch dataIn into a low-half holding register and produce no array write.
REQ-008 A C write with half=1 SHALL assert sa_wren=1 for one cycle, with sa_cin={dataIn, holding} and sa_crow=row.
REQ-009 A write to 0x400 with dataIn[0]=1 in IDLE SHALL, on the next cycle, enter RUN, clear done, set busy, and load cycle counter = 0.
REQ-010 In RUN:
- sa_en=1 and a_en=1 every cycle, with a_wren=0.
- The counter SHALL increment each cycle.
- When the counter = 3*DIM-2 (22 for DIM=8), the FSM SHALL return to IDLE, clear busy, and set done on that edge.
- sa_en SHALL be high for exactly 3*DIM-2 cycles.
REQ-011 In RUN, host writes to A, B, C and the start bit SHALL be dropped with no side effect; reads SHALL still be served.
REQ-012 done SHALL be sticky until the next accepted start or reset.
REQ-013 Reads SHALL set dataOut in the cycle after the request:
- C address: dataOut = half-selected 64 bits of sa_cout, with sa_crow = row driven combinationally in the request cycle.
- 0x400: dataOut = {62'b0, done, busy}.
- Otherwise dataOut = 0.
- dataOut SHALL hold its value between reads.
REQ-014 In RUN, sa_crow SHALL still follow host read addresses; the value read is undefined and is not checked.
REQ-015 Only one host operation SHALL occur per cycle; decode priority is RUN-drop, then address range.

Reset
REQ-016 Asserting rst_n=0 at any time, including mid-RUN, SHALL force:
- state to IDLE, counter to 0;
- busy=0, done=0;
- all enable outputs 0;
- dataOut, a_row, sa_crow and the holding register to 0.
REQ-017 The first host operation after rst_n deasserts SHALL be decoded normally.

Structure
REQ-018 A shared package tpu_pkg SHALL hold:
- address base/limit constants (A_BASE, B_BASE, C_BASE, CTRL_ADDR);
- the state enum (IDLE, RUN);
- the status bit positions.
REQ-019 One sub-module, tpu_addr_decode, SHALL be used: combinational addr to {sel_a, sel_b, sel_c, sel_ctrl, row, half}.
REQ-020 The expected implementation size is 150-300 lines; it SHALL contain no arithmetic beyond the counter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- A write: write addr 0x118, data 0x0807060504030201 -> one cycle with a_en=a_wren=1, a_row=3, a_din=0x0807060504030201.
- C write/read: write 0x320 = 0x1111, then 0x328 = 0x2222 -> sa_wren for one cycle, sa_crow=2, sa_cin={0x2222, 0x1111}. Then read 0x328 with sa_cout[127:64]=0x2222 -> dataOut=0x2222 the next cycle.
- Start/run: write 0x400 = 1 -> busy=1 next cycle, sa_en high for exactly 22 cycles, then busy=0, done=1. Read 0x400 -> dataOut=0x2.
- Writes during RUN: write 0x100 mid-RUN -> a_wren stays 0, b_en stays 0. Start during RUN -> cycle count unchanged (22 total).
- Reset mid-RUN: rst_n low at cycle 10 of RUN -> immediately busy=0, done=0, sa_en=0, dataOut=0. A new start after release runs the full 22 cycles.
- Unmapped access: write 0x500 -> no enables asserted. Read 0x500 -> dataOut=0.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host controller.
// Holds the host address map, the controller state encoding, the status-word
// bit positions and the RUN-phase length helper.
package tpu_pkg;

  // Host address map (inclusive byte ranges)
  localparam int unsigned A_BASE    = 'h100;
  localparam int unsigned A_LAST    = 'h13F;
  localparam int unsigned B_BASE    = 'h200;
  localparam int unsigned B_LAST    = 'h23F;
  localparam int unsigned C_BASE    = 'h300;
  localparam int unsigned C_LAST    = 'h37F;
  localparam int unsigned CTRL_ADDR = 'h400;

  // Bit positions inside the CTRL/STATUS read word
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  // Bit position of the start request in a CTRL write
  localparam int unsigned CTRL_START = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of cycles the array is enabled for one pass of a DIM x DIM array
  function automatic int unsigned run_cycles(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/tpu_ctrl_if.sv
// Host bus of the TPU controller.
// r_w     : 0 = read, 1 = write, sampled every cycle (every cycle is an operation)
// addr    : host byte address
// dataIn  : host write data
// dataOut : registered read data, updated the cycle after a read
interface tpu_ctrl_if #(
  parameter int unsigned ADDRW = 16,
  parameter int unsigned DATAW = 64
);
  logic             r_w;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] dataIn;
  logic [DATAW-1:0] dataOut;

  modport master (
    output r_w,
    output addr,
    output dataIn,
    input  dataOut
  );

  modport slave (
    input  r_w,
    input  addr,
    input  dataIn,
    output dataOut
  );
endinterface

// File: rtl/tpu_addr_decode.sv
// Combinational host address decoder.
// addr     : host byte address
// sel_a    : A row region      (row = addr[5:3])
// sel_b    : B row region
// sel_c    : C half-row region (row = addr[6:4], half = addr[3])
// sel_ctrl : CTRL/STATUS word
// row      : row index of the selected A or C region, 0 otherwise
// half     : C half select (0 = bits [63:0], 1 = bits [127:64])
module tpu_addr_decode
  import tpu_pkg::*;
#(
  parameter int unsigned ADDRW = 16,
  parameter int unsigned ROWW  = 3
) (
  input  logic [ADDRW-1:0] addr,
  output logic             sel_a,
  output logic             sel_b,
  output logic             sel_c,
  output logic             sel_ctrl,
  output logic [ROWW-1:0]  row,
  output logic             half
);

  always_comb begin
    sel_a    = (addr >= ADDRW'(A_BASE)) && (addr <= ADDRW'(A_LAST));
    sel_b    = (addr >= ADDRW'(B_BASE)) && (addr <= ADDRW'(B_LAST));
    sel_c    = (addr >= ADDRW'(C_BASE)) && (addr <= ADDRW'(C_LAST));
    sel_ctrl = (addr == ADDRW'(CTRL_ADDR));
    half     = addr[3];
    row      = '0;
    if (sel_a) begin
      row = addr[3 +: ROWW];
    end else if (sel_c) begin
      row = addr[4 +: ROWW];
    end
  end

endmodule

// File: rtl/tpu_ctrl.sv
// Host-side controller for a DIM x DIM systolic array.
// Decodes host reads/writes into memA row writes, memB row shifts and C row
// accesses, and sequences one RUN pass of run_cycles(DIM) cycles on start.
// clk, rst_n      : clock, asynchronous active-low reset
// host            : host bus (r_w, addr, dataIn, dataOut)
// a_en/a_wren     : memA enable / row write, a_row/a_din row index and data
// b_en/b_din      : memB shift enable and row data
// sa_en/sa_wren   : array enable / C row write
// sa_crow         : C row index, sa_cin C write data, sa_cout C read data
// busy/done       : status; done is sticky until the next accepted start
module tpu_ctrl
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned BITS_C  = 16,
  parameter int unsigned DIM     = 8,
  parameter int unsigned ADDRW   = 16,
  parameter int unsigned DATAW   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tpu_ctrl_if.slave                host,
  output logic                     a_en,
  output logic                     a_wren,
  output logic [$clog2(DIM)-1:0]   a_row,
  output logic [DIM*BITS_AB-1:0]   a_din,
  output logic                     b_en,
  output logic [DIM*BITS_AB-1:0]   b_din,
  output logic                     sa_en,
  output logic                     sa_wren,
  output logic [$clog2(DIM)-1:0]   sa_crow,
  output logic [DIM*BITS_C-1:0]    sa_cin,
  input  logic [DIM*BITS_C-1:0]    sa_cout,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned RowW   = $clog2(DIM);
  localparam int unsigned RunLen = run_cycles(DIM);
  localparam int unsigned CntW   = $clog2(RunLen + 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_nxt;
  logic             busy_q;
  logic             done_q;
  logic             run_q;
  logic [DATAW-1:0] hold_q;
  logic [DATAW-1:0] dout_q;

  logic             sel_a;
  logic             sel_b;
  logic             sel_c;
  logic             sel_ctrl;
  logic [RowW-1:0]  row;
  logic             half;

  logic             wr;
  logic             rd;
  logic             idle;
  logic             a_wr;
  logic             b_wr;
  logic             c_lo_wr;
  logic             c_hi_wr;
  logic             start;
  logic [DATAW-1:0] rd_data;
  logic [DATAW-1:0] status;

  tpu_addr_decode #(
    .ADDRW (ADDRW),
    .ROWW  (RowW)
  ) u_decode (
    .addr     (host.addr),
    .sel_a    (sel_a),
    .sel_b    (sel_b),
    .sel_c    (sel_c),
    .sel_ctrl (sel_ctrl),
    .row      (row),
    .half     (half)
  );

  // Host operation qualification. Write strobes are combinational in the
  // request cycle, so they are gated with rst_n to stay low while in reset.
  always_comb begin
    idle    = (state_q == IDLE);
    wr      = host.r_w & rst_n;
    rd      = ~host.r_w & rst_n;
    // RUN drops every host write before the address is considered
    a_wr    = wr & idle & sel_a;
    b_wr    = wr & idle & sel_b;
    c_lo_wr = wr & idle & sel_c & ~half;
    c_hi_wr = wr & idle & sel_c & half;
    start   = wr & idle & sel_ctrl & host.dataIn[CTRL_START];
    cnt_nxt = cnt_q + 1'b1;
  end

  // Array-side outputs
  always_comb begin
    a_en    = run_q | a_wr;
    a_wren  = a_wr;
    a_row   = a_wr ? row : '0;
    a_din   = host.dataIn;
    b_en    = b_wr;
    b_din   = host.dataIn;
    sa_en   = run_q;
    sa_wren = c_hi_wr;
    // C row follows any C-region access, reads included, also during RUN
    sa_crow = (rst_n && sel_c) ? row : '0;
    sa_cin  = {host.dataIn, hold_q};
  end

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = busy_q;
    status[STAT_DONE] = done_q;
    rd_data           = '0;
    if (sel_c) begin
      rd_data = half ? sa_cout[DATAW +: DATAW] : sa_cout[0 +: DATAW];
    end else if (sel_ctrl) begin
      rd_data = status;
    end
  end

  // Controller FSM with registered status and array enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            run_q   <= 1'b1;
          end
        end
        RUN: begin
          cnt_q <= cnt_nxt;
          if (cnt_nxt == CntW'(RunLen)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            run_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Read data register and C low-half holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      hold_q <= '0;
    end else begin
      if (rd) begin
        dout_q <= rd_data;
      end
      if (c_lo_wr) begin
        hold_q <= host.dataIn;
      end
    end
  end

  assign host.dataOut = dout_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_tpu_ctrl.sv
// Scoreboard bench for tpu_ctrl: the stimulus process runs a behavioural model
// and queues the expected per-cycle status and the expected write payloads;
// a monitor samples the DUT at the falling edge and pops/compares.
module tb_tpu_ctrl;

  localparam int RUN_LEN = 3 * 8 - 2;

  typedef struct packed {
    logic busy;
    logic done;
    logic sa_en;
    logic a_en;
    logic a_wren;
    logic b_en;
    logic sa_wren;
  } ctl_t;

  typedef struct {
    ctl_t        ctl;
    bit          dcare;
    logic [63:0] dout;
  } rec_t;

  logic         clk;
  logic         rst_n;
  logic         a_en, a_wren, b_en, sa_en, sa_wren, busy, done;
  logic [2:0]   a_row, sa_crow;
  logic [63:0]  a_din, b_din;
  logic [127:0] sa_cin, sa_cout;
  logic [127:0] cmem [8];

  tpu_ctrl_if #(.ADDRW(16), .DATAW(64)) host_if ();

  tpu_ctrl #(
    .BITS_AB (8),
    .BITS_C  (16),
    .DIM     (8),
    .ADDRW   (16),
    .DATAW   (64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (host_if),
    .a_en    (a_en),
    .a_wren  (a_wren),
    .a_row   (a_row),
    .a_din   (a_din),
    .b_en    (b_en),
    .b_din   (b_din),
    .sa_en   (sa_en),
    .sa_wren (sa_wren),
    .sa_crow (sa_crow),
    .sa_cin  (sa_cin),
    .sa_cout (sa_cout),
    .busy    (busy),
    .done    (done)
  );

  // Behavioural C storage of the array, read by row
  assign sa_cout = cmem[sa_crow];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  rec_t          q_rec [$];
  logic [66:0]   q_a [$];
  logic [63:0]   q_b [$];
  logic [130:0]  q_c [$];

  // Reference model state
  int          m_left  = 0;
  bit          m_done  = 0;
  logic [63:0] m_dout  = '0;
  bit          m_known = 1;
  logic [63:0] m_hold  = '0;

  task automatic model_reset();
    m_left  = 0;
    m_done  = 0;
    m_dout  = '0;
    m_known = 1;
    m_hold  = '0;
  endtask

  task automatic model_step(input logic rw, input logic [15:0] a, input logic [63:0] d);
    rec_t r;
    bit   running, start;
    bit   is_a, is_b, is_c, is_ctl;
    int   arow, crow, chalf;
    running = (m_left > 0);
    start   = 0;
    is_a    = (a >= 16'h100) && (a < 16'h140);
    is_b    = (a >= 16'h200) && (a < 16'h240);
    is_c    = (a >= 16'h300) && (a < 16'h380);
    is_ctl  = (a == 16'h400);
    arow    = (int'(a) - 'h100) / 8;
    crow    = (int'(a) - 'h300) / 16;
    chalf   = ((int'(a) - 'h300) / 8) % 2;
    r.ctl       = '0;
    r.ctl.busy  = running;
    r.ctl.done  = m_done;
    r.ctl.sa_en = running;
    r.ctl.a_en  = running;
    r.dcare     = m_known;
    r.dout      = m_dout;
    if (rw && !running) begin
      if (is_a) begin
        r.ctl.a_en   = 1;
        r.ctl.a_wren = 1;
        q_a.push_back({3'(arow), d});
      end else if (is_b) begin
        r.ctl.b_en = 1;
        q_b.push_back(d);
      end else if (is_c) begin
        if (chalf == 0) begin
          m_hold = d;
        end else begin
          r.ctl.sa_wren = 1;
          q_c.push_back({3'(crow), d, m_hold});
        end
      end else if (is_ctl && d[0]) begin
        start = 1;
      end
    end
    if (!rw) begin
      m_known = 1;
      if (is_c) begin
        if (running) m_known = 0;
        else m_dout = cmem[crow][64*chalf +: 64];
      end else if (is_ctl) begin
        m_dout = {62'b0, m_done, running};
      end else begin
        m_dout = '0;
      end
    end
    q_rec.push_back(r);
    if (running) begin
      m_left--;
      if (m_left == 0) m_done = 1;
    end
    if (start) begin
      m_left = RUN_LEN;
      m_done = 0;
    end
  endtask

  task automatic op(input logic rw, input logic [15:0] a, input logic [63:0] d);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    host_if.r_w    = rw;
    host_if.addr   = a;
    host_if.dataIn = d;
    model_step(rw, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b1, 16'h500, 64'h0);
  endtask

  // Reset held low for n cycles while an A write is presented on the bus
  task automatic do_reset(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n          = 1'b0;
      host_if.r_w    = 1'b1;
      host_if.addr   = 16'h118;
      host_if.dataIn = 64'hdead_beef_0000_0001;
      model_reset();
      r.ctl   = '0;
      r.dcare = 1;
      r.dout  = '0;
      q_rec.push_back(r);
    end
  endtask

  // Monitor: one expected record per cycle plus payloads on each DUT strobe
  initial begin
    rec_t  r;
    ctl_t  act;
    logic [66:0]  ea;
    logic [63:0]  eb;
    logic [130:0] ec;
    forever begin
      @(negedge clk);
      if (q_rec.size() == 0) continue;
      r   = q_rec.pop_front();
      act = '{busy: busy, done: done, sa_en: sa_en, a_en: a_en, a_wren: a_wren,
              b_en: b_en, sa_wren: sa_wren};
      n_chk++;
      if (act !== r.ctl) begin
        n_err++;
        $display("FAIL ctl t=%0t got busy,done,sa_en,a_en,a_wren,b_en,sa_wren=%b want=%b",
                 $time, act, r.ctl);
      end
      if (r.dcare) begin
        n_chk++;
        if (host_if.dataOut !== r.dout) begin
          n_err++;
          $display("FAIL dataOut t=%0t got=%h want=%h", $time, host_if.dataOut, r.dout);
        end
      end
      if (a_wren === 1'b1) begin
        n_chk++;
        if (q_a.size() == 0) begin
          n_err++;
          $display("FAIL a_write t=%0t got unexpected row=%0d din=%h want none",
                   $time, a_row, a_din);
        end else begin
          ea = q_a.pop_front();
          if ({a_row, a_din} !== ea) begin
            n_err++;
            $display("FAIL a_write t=%0t got row=%0d din=%h want row=%0d din=%h",
                     $time, a_row, a_din, ea[66:64], ea[63:0]);
          end
        end
      end
      if (b_en === 1'b1) begin
        n_chk++;
        if (q_b.size() == 0) begin
          n_err++;
          $display("FAIL b_write t=%0t got unexpected din=%h want none", $time, b_din);
        end else begin
          eb = q_b.pop_front();
          if (b_din !== eb) begin
            n_err++;
            $display("FAIL b_write t=%0t got din=%h want din=%h", $time, b_din, eb);
          end
        end
      end
      if (sa_wren === 1'b1) begin
        n_chk++;
        if (q_c.size() == 0) begin
          n_err++;
          $display("FAIL c_write t=%0t got unexpected row=%0d cin=%h want none",
                   $time, sa_crow, sa_cin);
        end else begin
          ec = q_c.pop_front();
          if ({sa_crow, sa_cin} !== ec) begin
            n_err++;
            $display("FAIL c_write t=%0t got row=%0d cin=%h want row=%0d cin=%h",
                     $time, sa_crow, sa_cin, ec[130:128], ec[127:0]);
          end
        end
      end
    end
  end

  initial begin
    int          k;
    logic [63:0] d;
    logic [15:0] a;
    rst_n          = 1'b0;
    host_if.r_w    = 1'b0;
    host_if.addr   = '0;
    host_if.dataIn = '0;
    for (int i = 0; i < 8; i++) cmem[i] = {$urandom, $urandom, $urandom, $urandom};
    cmem[2][127:64] = 64'h2222;

    do_reset(3);
    op(1'b0, 16'h400, 64'h0);                       // status right after reset
    op(1'b1, 16'h118, 64'h0807_0605_0403_0201);     // A write, row 3
    op(1'b1, 16'h320, 64'h1111);                    // C low half, no array write
    op(1'b1, 16'h328, 64'h2222);                    // C high half, row 2
    op(1'b0, 16'h328, 64'h0);                       // C read upper half
    idle(1);
    op(1'b1, 16'h208, 64'hcafe_f00d_1234_5678);     // B write
    op(1'b1, 16'h400, 64'h1);                       // start
    op(1'b0, 16'h400, 64'h0);                       // status while busy
    op(1'b1, 16'h100, 64'h1);                       // dropped during RUN
    op(1'b1, 16'h200, 64'h2);
    op(1'b1, 16'h338, 64'h3);
    op(1'b1, 16'h400, 64'h1);                       // start ignored during RUN
    idle(RUN_LEN);
    op(1'b0, 16'h400, 64'h0);                       // done=1, busy=0
    idle(1);
    op(1'b1, 16'h500, 64'hffff_ffff_ffff_ffff);     // unmapped write
    op(1'b0, 16'h500, 64'h0);                       // unmapped read
    op(1'b0, 16'h400, 64'h0);
    op(1'b1, 16'h400, 64'h1);                       // start, then reset mid-RUN
    idle(9);
    do_reset(2);
    op(1'b1, 16'h400, 64'h1);                       // first op after reset
    idle(RUN_LEN + 2);
    op(1'b0, 16'h400, 64'h0);
    idle(1);

    for (int i = 0; i < 500; i++) begin
      k = $urandom_range(0, 9);
      d = {$urandom, $urandom};
      case (k)
        0: op(1'b1, 16'h100 + 16'($urandom_range(0, 63)), d);
        1: op(1'b1, 16'h200 + 16'($urandom_range(0, 63)), d);
        2, 3: op(1'b1, 16'h300 + 16'($urandom_range(0, 127)), d);
        4: op(1'b0, 16'h300 + 16'($urandom_range(0, 127)), d);
        5: op(1'b0, 16'h400, d);
        6: op(1'b1, 16'h400, d);
        7: begin
          a = 16'($urandom);
          op(1'b1, a, d);
        end
        8: begin
          a = 16'($urandom);
          op(1'b0, a, d);
        end
        default: idle(1);
      endcase
    end
    idle(RUN_LEN + 2);

    @(negedge clk);
    #1;
    n_chk++;
    if (q_rec.size() != 0) begin
      n_err++;
      $display("FAIL drain_rec got=%0d pending want=0", q_rec.size());
    end
    n_chk++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      n_err++;
      $display("FAIL drain_writes got a=%0d b=%0d c=%0d missing want 0",
               q_a.size(), q_b.size(), q_c.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
